// File: rtl/mem_bus_responder_if.sv
// CPU-side memory bus: single-cycle read/write requests from the CPU,
// read data plus ready/error strobes from the responder.
interface mem_bus_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_mem_read;
    logic                  cpu_mem_write;
    logic [ADDR_WIDTH-1:0] cpu_mem_address;
    logic [DATA_WIDTH-1:0] cpu_mem_wdata;
    logic [DATA_WIDTH-1:0] cpu_mem_rdata;
    logic                  cpu_mem_ready;
    logic                  bus_error;

    modport master (
        output cpu_mem_read,
        output cpu_mem_write,
        output cpu_mem_address,
        output cpu_mem_wdata,
        input  cpu_mem_rdata,
        input  cpu_mem_ready,
        input  bus_error
    );

    modport slave (
        input  cpu_mem_read,
        input  cpu_mem_write,
        input  cpu_mem_address,
        input  cpu_mem_wdata,
        output cpu_mem_rdata,
        output cpu_mem_ready,
        output bus_error
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory bus target: decodes CPU requests into RAM / ROM / I/O / unmapped
// space and returns read data with a one-cycle ready strobe.
module mem_bus_responder #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] RAM_TOP        = 16'h7FFF,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE        = 16'hE000,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE       = 16'hF000,
    parameter int                    IO_WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_responder_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  io_rd,
    output logic                  io_wr,
    output logic [7:0]            io_addr,
    output logic [DATA_WIDTH-1:0] io_wdata,
    input  logic [DATA_WIDTH-1:0] io_rdata
);

    localparam logic [ADDR_WIDTH-1:0] IO_TOP   = IO_BASE + ADDR_WIDTH'(255);
    localparam logic [3:0]            CNT_LOAD = 4'(IO_WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SEL_RAM, SEL_ROM, SEL_IO, SEL_ERR} sel_t;

    state_t                state_q, state_d;
    sel_t                  sel_q, sel_d;
    logic                  rd_q, rd_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    logic                  req_rd, req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  hit_ram, hit_io, hit_rom, illegal;
    logic [DATA_WIDTH-1:0] fwd_data;

    function automatic logic in_ram(input logic [ADDR_WIDTH-1:0] a);
        return a <= RAM_TOP;
    endfunction

    function automatic logic in_io(input logic [ADDR_WIDTH-1:0] a);
        return (a >= IO_BASE) && (a <= IO_TOP);
    endfunction

    function automatic logic in_rom(input logic [ADDR_WIDTH-1:0] a);
        return a >= ROM_BASE;
    endfunction

    assign req_rd   = bus.cpu_mem_read;
    assign req_wr   = bus.cpu_mem_write;
    assign req_addr = bus.cpu_mem_address;
    assign hit_ram  = in_ram(req_addr);
    assign hit_io   = in_io(req_addr);
    assign hit_rom  = in_rom(req_addr);
    // Conflicting strobes, writes into ROM and gaps in the map are all refused.
    assign illegal  = (req_rd && req_wr) || (hit_rom && req_wr) ||
                      !(hit_ram || hit_io || hit_rom);

    always_comb begin
        fwd_data = hold_q;
        unique case (sel_q)
            SEL_ERR: fwd_data = '1;
            SEL_RAM: fwd_data = rd_q ? ram_rdata : hold_q;
            SEL_ROM: fwd_data = rom_rdata;
            SEL_IO:  fwd_data = hold_q;
            default: fwd_data = hold_q;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        rd_d              = rd_q;
        cnt_d             = cnt_q;
        hold_d            = hold_q;
        ram_addr          = '0;
        ram_we            = 1'b0;
        ram_wdata         = '0;
        rom_addr          = '0;
        io_rd             = 1'b0;
        io_wr             = 1'b0;
        io_addr           = '0;
        io_wdata          = '0;
        bus.cpu_mem_rdata = hold_q;
        bus.cpu_mem_ready = 1'b0;
        bus.bus_error     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_rd || req_wr) begin
                    rd_d = req_rd && !req_wr;
                    if (illegal) begin
                        sel_d   = SEL_ERR;
                        state_d = S_RESP;
                    end else if (hit_ram) begin
                        ram_addr  = req_addr;
                        ram_we    = req_wr;
                        ram_wdata = req_wr ? bus.cpu_mem_wdata : '0;
                        sel_d     = SEL_RAM;
                        state_d   = S_RESP;
                    end else if (hit_rom) begin
                        rom_addr = req_addr - ROM_BASE;
                        sel_d    = SEL_ROM;
                        state_d  = S_RESP;
                    end else begin
                        io_addr  = 8'(req_addr - IO_BASE);
                        io_rd    = req_rd;
                        io_wr    = req_wr;
                        io_wdata = req_wr ? bus.cpu_mem_wdata : '0;
                        cnt_d    = CNT_LOAD;
                        sel_d    = SEL_IO;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // io_rdata is only guaranteed valid in the final wait cycle.
                if (cnt_q == 4'd0) begin
                    if (rd_q) hold_d = io_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                bus.cpu_mem_ready = 1'b1;
                bus.bus_error     = (sel_q == SEL_ERR);
                bus.cpu_mem_rdata = fwd_data;
                if (rd_q) hold_d = fwd_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset suppresses every strobe in its own cycle, including a write
        // that happens to be presented alongside it.
        if (reset) begin
            ram_addr          = '0;
            ram_we            = 1'b0;
            ram_wdata         = '0;
            rom_addr          = '0;
            io_rd             = 1'b0;
            io_wr             = 1'b0;
            io_addr           = '0;
            io_wdata          = '0;
            bus.cpu_mem_rdata = '0;
            bus.cpu_mem_ready = 1'b0;
            bus.bus_error     = 1'b0;
        end
    end

    // State register boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_RAM;
            rd_q    <= 1'b0;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with synchronous RAM/ROM models and a
// scoreboard of expected completions.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ram_addr, rom_addr;
    logic        ram_we, io_rd, io_wr;
    logic [7:0]  ram_wdata, ram_rdata, rom_rdata, io_addr, io_wdata;
    logic [7:0]  io_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    logic [7:0] ram_mem [0:255] = '{default: 8'h00};
    logic [7:0] rom_mem [0:255] = '{0: 8'hA5, 1: 8'hF5, default: 8'h00};

    always #5 clk = ~clk;

    mem_bus_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    mem_bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr[7:0]];
        rom_rdata <= rom_mem[rom_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_mem_read    = rd;
        bus.cpu_mem_write   = wr;
        bus.cpu_mem_address = a;
        bus.cpu_mem_wdata   = d;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.cpu_mem_read  = 1'b0;
        bus.cpu_mem_write = 1'b0;
    endtask

    // Completion monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.cpu_mem_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 16'(bus.cpu_mem_ready), 16'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_rdata"}, 16'(bus.cpu_mem_rdata), 16'(e.data));
                chk({e.tag, "_err"}, 16'(bus.bus_error), 16'(e.err));
            end
        end else if (bus.bus_error !== 1'b0) begin
            chk("stray_bus_error", 16'(bus.bus_error), 16'd0);
        end
    end

    initial begin
        reset               = 1'b1;
        io_rdata            = 8'h00;
        bus.cpu_mem_read    = 1'b0;
        bus.cpu_mem_write   = 1'b0;
        bus.cpu_mem_address = 16'h0000;
        bus.cpu_mem_wdata   = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", 16'(bus.cpu_mem_rdata), 16'h00);
        chk("rst_ready", 16'(bus.cpu_mem_ready), 16'd0);
        chk("rst_ram_we", 16'(ram_we), 16'd0);
        chk("rst_io_strobes", 16'({io_rd, io_wr}), 16'd0);
        chk("rst_addrs", ram_addr | rom_addr | 16'(io_addr), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rdata", 16'(bus.cpu_mem_rdata), 16'h00);
        step();

        // ROM reads and hold of last read data
        sb.push_back('{"rom_f000", 8'hA5, 1'b0});
        drive(1'b1, 1'b0, 16'hF000, 8'h00);
        chk("rom_f000_ready_n", 16'(bus.cpu_mem_ready), 16'd0);
        step(); @(negedge clk);
        chk("rom_f000_ready_n1", 16'(bus.cpu_mem_ready), 16'd1);
        step(); @(negedge clk);
        chk("rom_hold_a5", 16'(bus.cpu_mem_rdata), 16'hA5);
        step();
        sb.push_back('{"rom_f001", 8'hF5, 1'b0});
        drive(1'b1, 1'b0, 16'hF001, 8'h00);
        chk("rom_f001_addr", rom_addr, 16'h0001);
        chk("rom_hold_before", 16'(bus.cpu_mem_rdata), 16'hA5);
        step(); @(negedge clk); step();

        // RAM write then read back
        sb.push_back('{"ram_wr10", 8'hF5, 1'b0});
        drive(1'b0, 1'b1, 16'h0010, 8'h3C);
        chk("ram_wr_we", 16'(ram_we), 16'd1);
        chk("ram_wr_addr", ram_addr, 16'h0010);
        chk("ram_wr_data", 16'(ram_wdata), 16'h3C);
        step(); @(negedge clk);
        chk("ram_wr_ready", 16'(bus.cpu_mem_ready), 16'd1);
        step();
        sb.push_back('{"ram_rd10", 8'h3C, 1'b0});
        drive(1'b1, 1'b0, 16'h0010, 8'h00);
        chk("ram_rd_we", 16'(ram_we), 16'd0);
        step(); @(negedge clk); step();

        // I/O read with wait states; a request during WAIT is ignored
        sb.push_back('{"io_rd", 8'h5A, 1'b0});
        drive(1'b1, 1'b0, 16'hE001, 8'h00);
        chk("io_rd_strobe", 16'(io_rd), 16'd1);
        chk("io_rd_addr", 16'(io_addr), 16'h0001);
        step();
        drive(1'b1, 1'b0, 16'hF000, 8'h00);
        chk("io_ignored_strobe", 16'(io_rd), 16'd0);
        chk("io_ready_n1", 16'(bus.cpu_mem_ready), 16'd0);
        step();
        io_rdata = 8'h5A;
        @(negedge clk);
        chk("io_ready_n2", 16'(bus.cpu_mem_ready), 16'd0);
        step();
        io_rdata = 8'h00;
        @(negedge clk);
        chk("io_ready_n3", 16'(bus.cpu_mem_ready), 16'd1);
        step(); @(negedge clk);
        chk("io_hold_5a", 16'(bus.cpu_mem_rdata), 16'h5A);
        step();

        // I/O write leaves the held read data alone
        sb.push_back('{"io_wr", 8'h5A, 1'b0});
        drive(1'b0, 1'b1, 16'hE010, 8'h42);
        chk("io_wr_strobe", 16'({io_rd, io_wr}), 16'b01);
        chk("io_wr_addr", 16'(io_addr), 16'h0010);
        chk("io_wr_data", 16'(io_wdata), 16'h42);
        step(); step(); step(); @(negedge clk);
        chk("io_wr_ready_n3", 16'(bus.cpu_mem_ready), 16'd1);
        step();

        // Illegal accesses
        sb.push_back('{"rom_write", 8'hFF, 1'b1});
        drive(1'b0, 1'b1, 16'hF005, 8'h77);
        chk("rom_write_strobes", 16'({ram_we, io_rd, io_wr}), 16'd0);
        step(); @(negedge clk); step();
        sb.push_back('{"unmapped_9000", 8'hFF, 1'b1});
        drive(1'b1, 1'b0, 16'h9000, 8'h00);
        chk("unmapped_strobes", 16'({ram_we, io_rd, io_wr}), 16'd0);
        step(); @(negedge clk); step(); @(negedge clk);
        chk("unmapped_hold_ff", 16'(bus.cpu_mem_rdata), 16'h00FF);
        step();

        // Read and write together must not touch RAM
        sb.push_back('{"ram_wr20", 8'hFF, 1'b0});
        drive(1'b0, 1'b1, 16'h0020, 8'h11);
        step(); @(negedge clk); step();
        sb.push_back('{"rdwr_err", 8'hFF, 1'b1});
        drive(1'b1, 1'b1, 16'h0020, 8'h99);
        chk("rdwr_ram_we", 16'(ram_we), 16'd0);
        step(); @(negedge clk); step();
        sb.push_back('{"ram_rd20", 8'h11, 1'b0});
        drive(1'b1, 1'b0, 16'h0020, 8'h00);
        step(); @(negedge clk); step();

        // Reset during an I/O wait abandons it; a write alongside reset is dropped
        drive(1'b1, 1'b0, 16'hE002, 8'h00);
        chk("rst_io_rd", 16'(io_rd), 16'd1);
        step();
        reset = 1'b1;
        drive(1'b0, 1'b1, 16'h0030, 8'h77);
        chk("rst_write_we", 16'(ram_we), 16'd0);
        chk("rst_wait_rdata", 16'(bus.cpu_mem_rdata), 16'h00);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rdata", 16'(bus.cpu_mem_rdata), 16'h00);
        chk("post_rst_ready", 16'(bus.cpu_mem_ready), 16'd0);
        step(); step();
        sb.push_back('{"rom_after_rst", 8'hA5, 1'b0});
        drive(1'b1, 1'b0, 16'hF000, 8'h00);
        step(); @(negedge clk);
        chk("rom_after_rst_ready", 16'(bus.cpu_mem_ready), 16'd1);
        step();
        sb.push_back('{"ram_rd30", 8'h00, 1'b0});
        drive(1'b1, 1'b0, 16'h0030, 8'h00);
        step(); @(negedge clk);
        repeat (3) step();

        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Target side of the CPU memory bus: accepts the single-cycle read/write requests the CPU fetch/execute FSM issues and decodes the address into RAM, ROM, I/O or unmapped space. It returns read data and a ready strobe with fixed, documented latency. Sits in `computer` between `u_cpu` and `u_ram`/`u_rom`/I/O peripherals, replacing ad-hoc address muxing.

## Interface
- ADDR_WIDTH, 16, CPU address width
- DATA_WIDTH, 8, data width
- RAM_TOP, 16'h7FFF, last RAM address; RAM is 0x0000..RAM_TOP
- IO_BASE, 16'hE000, I/O window base, 256 bytes (IO_BASE..IO_BASE+0xFF)
- ROM_BASE, 16'hF000, ROM is ROM_BASE..0xFFFF
- IO_WAIT_STATES, 2, extra cycles for I/O access; legal range 1..15
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_mem_read  in  1  read request, valid for one cycle
- cpu_mem_write  in  1  write request, valid for one cycle
- cpu_mem_address  in  ADDR_WIDTH  request address
- cpu_mem_wdata  in  DATA_WIDTH  write data
- cpu_mem_rdata  out  DATA_WIDTH  read data to CPU
- cpu_mem_ready  out  1  one-cycle completion strobe
- bus_error  out  1  one-cycle strobe on illegal access
- ram_addr / rom_addr  out  ADDR_WIDTH  address to synchronous-read memories (offset from region base)
- ram_we  out  1  RAM write enable; ram_wdata out DATA_WIDTH
- ram_rdata / rom_rdata  in  DATA_WIDTH  registered memory read data, valid the cycle after the address is presented
- io_rd / io_wr  out  1  I/O strobes; io_addr out 8; io_wdata out DATA_WIDTH
- io_rdata  in  DATA_WIDTH  I/O read data, valid in the last WAIT cycle

## Operation
- States: IDLE, WAIT, RESP. Requests are accepted only in IDLE. Requests in WAIT/RESP are ignored (no side effects).
- IDLE with request: decode combinationally. Address, enables and strobes are driven in the request cycle N.
  - RAM read/write: ram_addr driven, ram_we = cpu_mem_write. Go to RESP with sel_q = RAM.
  - ROM read: rom_addr = address - ROM_BASE. Go to RESP with sel_q = ROM.
  - I/O read/write: io_rd/io_wr pulse in N. Counter loads IO_WAIT_STATES-1. Go to WAIT.
  - Error cases: ROM write, unmapped access (RAM_TOP < addr < IO_BASE, or IO_BASE+0xFF < addr < ROM_BASE), or read and write both asserted.
    - No memory/I/O strobe is issued.
    - bus_error pulses in N+1.
    - Go to RESP with sel_q = ERR; read data is 0xFF.
- WAIT: counter decrements each cycle. In the cycle the counter reaches 0, capture io_rdata into hold_q and go to RESP.
- RESP: cpu_mem_ready = 1 for exactly one cycle, then return to IDLE.
  - cpu_mem_rdata = ram_rdata / rom_rdata for RAM/ROM, hold_q for I/O, 0xFF for ERR.
  - The forwarded value is captured into hold_q at the end of RESP.
- Outside RESP, cpu_mem_rdata = hold_q. The last read data stays stable until the next read completes.
- Writes do not update hold_q. For writes, rdata in RESP equals the unchanged hold_q.
- Reset (any state): go to IDLE, counter cleared, hold_q = 0x00. Any WAIT in progress is abandoned with no ready. A write sampled in the same cycle as reset is not committed (ram_we, io_wr forced 0).

## Timing
- Reset values:
  - cpu_mem_rdata = 0x00
  - cpu_mem_ready = 0, bus_error = 0
  - ram_we, io_rd, io_wr = 0
  - address outputs = 0
- RAM/ROM: request in cycle N, ready and data in N+1. This matches the CPU's READ_BYTE -> LATCH_BYTE sequence, and the CPU never stalls on these.
- I/O: request in N, ready and data in N+1+IO_WAIT_STATES. The CPU must hold in LATCH_BYTE until ready.
- Error: ready and bus_error together in N+1, with data 0xFF.
- Back-to-back: the earliest next accepted request is the cycle after RESP, so throughput is one access per 2 cycles.
- A RAM write commits at the rising edge ending cycle N. A read of the same address issued in N+2 returns the new value.

## Test plan
- ROM[0x000]=0xA5, ROM[0x001]=0xF5. Read 0xF000 in N -> ready=1 and rdata=0xA5 in N+1. rdata stays 0xA5 until a read of 0xF001 completes with 0xF5.
- Write 0x3C to 0x0010 -> ram_we=1 in N and ready in N+1. Then read 0x0010 -> rdata=0x3C.
- IO_WAIT_STATES=2, io_rdata=0x5A. Read 0xE001 -> io_rd in N with io_addr=0x01, ready only in N+3, rdata=0x5A. A read issued in N+1 is ignored.
- Write to 0xF005 -> no ram_we/io_wr, bus_error=1 and ready=1 in N+1. Read 0x9000 -> rdata=0xFF with bus_error.
- Read and write both asserted at 0x0020 -> bus_error, RAM[0x20] unchanged.
- Assert reset during WAIT of an I/O read -> next cycle state IDLE, rdata=0x00, no ready pulse. A subsequent ROM read completes normally in N+1.
